wb_daq_data_packer: RTL and testbench
=====================================

Name: wb_daq_data_packer

Overview:
Parametrised successor to the DAQ aggregation stage. Packs ADC samples of run-time selectable width (8/16/32 bits) into dw-bit words for the DAQ FIFO. Adds FIFO backpressure with a one-word holding register, flush of partial words, and a sticky overflow flag. Sits between the ADC capture interface and the DAQ write FIFO, in the wb_clk domain.

Parameters:
dw, 32, output word width; legal values 32 or 64.
adc_dw, 16, ADC sample bus width (8..32); samples are zero-extended or truncated to the selected width.
SYNC_STAGES, 3, synchroniser depth on data_ready (>=2).
TIMEOUT_W, 16, width of the auto-flush timeout counter (optional feature only).

Ports:
wb_clk  in  1  clock
wb_rst  in  1  asynchronous active-high reset
enable  in  1  1 = accept samples
data_ready  in  1  ADC sample strobe (asynchronous level/pulse)
data_width  in  2  0=8b, 1=16b, 2=32b, 3=reserved
adc_data_in  in  adc_dw  ADC sample
flush  in  1  single-cycle pulse: emit the partial word, zero-padded
fifo_full  in  1  downstream FIFO full
overflow_clr  in  1  clears overflow
data_out  out  dw  packed word; sample 0 in the LSBs
fifo_push  out  1  one-cycle write strobe
busy  out  1  partial word present or holding register full
overflow  out  1  sticky: a completed word was dropped

Behaviour:
- Reset values: data_out=0, fifo_push=0, overflow=0, busy=0. Slot index=0, holding register empty, synchroniser cleared.
- data_ready passes through a SYNC_STAGES flop chain. Rising-edge detect on the last stage produces one sample event per strobe, so a held-high level yields exactly one sample.
- Sample capture: on an edge with enable=1 and data_width!=3, adc_data_in is registered in the same cycle. Edges with enable=0 or data_width=3 are ignored. A partial word is retained while enable=0.
- Width latch: data_width is latched as cur_width when a sample lands in slot 0. Mid-word changes take effect only from the next word.
- Slots per word = dw/width: 4/2/1 for dw=32, 8/4/2 for dw=64. A sample is placed at bit offset slot*width.
- Word completion on the last slot, or on flush with slot>0:
  - The word moves to the holding register and the pack register/slot resets to 0.
  - Unused slots read as 0.
  - flush with slot=0 and no new sample is a no-op.
- Flush in the same cycle as a captured sample: the sample is placed first, then the word is emitted.
- Output: when the holding register is full and fifo_full=0, the next edge sets data_out=holding, fifo_push=1 and empties the holding register. fifo_push is a single-cycle pulse; data_out holds its value until the next push.
- Overflow: a word completes while the holding register is full and is not draining that cycle → the new word is dropped and overflow is set. Completion in the same cycle as a drain is legal and refills the holding register.
- overflow_clr clears overflow. A simultaneous set wins.
- Latency: synchronised edge → capture 1 cycle → pack 1 cycle → fifo_push 1 cycle. The last sample appears on fifo_push 3 cycles after the detected edge when fifo_full=0.
- Reset mid-word discards all partial and held data without emitting a push.

Optional Feature:
DAQ_PACK_TIMEOUT_EN
- Defined:
  - Adds input timeout_cycles[TIMEOUT_W-1:0].
  - A counter runs while slot>0 and restarts on every accepted sample.
  - Reaching timeout_cycles acts as an internal flush.
  - timeout_cycles=0 disables the timer.
- Undefined: no port, no counter; partial words leave only via completion or flush.

Test Plan:
- dw=32, width=0, samples 0x11,0x22,0x33,0x44, fifo_full=0 → one fifo_push, data_out=0x44332211.
- width=1, samples 0xAAAA,0x5555 then 0x1234 then flush → pushes 0x5555AAAA then 0x00001234.
- width=2, fifo_full=1, three samples → first word pushed after fifo_full drops. Second word is held, third is dropped, and overflow=1. overflow_clr clears it.
- data_ready held high 20 cycles with one sample → exactly one slot filled. data_width changed 0→1 after slot 0 → the word still packs four 8-bit samples.
- wb_rst asserted after 2 of 4 bytes → no push, busy=0. Next 4 bytes produce one clean word.
- DAQ_PACK_TIMEOUT_EN, timeout_cycles=10, one 8-bit sample 0x7F → push 0x0000007F about 10 cycles later.

Source files
------------

// File: rtl/wb_daq_data_packer_if.sv
// Bus bundle between the ADC capture side, the DAQ write FIFO and the
// sample packer. The packer connects through the slave modport; whatever
// drives the ADC/FIFO side (capture logic, FIFO wrapper, bench) uses master.
interface wb_daq_data_packer_if #(
    parameter int dw     = 32,
    parameter int adc_dw = 16
);
    logic              enable;
    logic              data_ready;
    logic [1:0]        data_width;
    logic [adc_dw-1:0] adc_data_in;
    logic              flush;
    logic              fifo_full;
    logic              overflow_clr;
    logic [dw-1:0]     data_out;
    logic              fifo_push;
    logic              busy;
    logic              overflow;

    modport master (
        output enable, data_ready, data_width, adc_data_in, flush,
               fifo_full, overflow_clr,
        input  data_out, fifo_push, busy, overflow
    );

    modport slave (
        input  enable, data_ready, data_width, adc_data_in, flush,
               fifo_full, overflow_clr,
        output data_out, fifo_push, busy, overflow
    );
endinterface

// File: rtl/wb_daq_data_packer.sv
// DAQ sample packer: packs 8/16/32-bit ADC samples into dw-bit words for the
// DAQ write FIFO, with a one-word holding register for FIFO backpressure,
// partial-word flush and a sticky overflow flag. All logic runs on wb_clk.
// Optional build macro DAQ_PACK_TIMEOUT_EN adds the timeout_cycles input and
// an auto-flush timer for partial words (TIMEOUT_W sets its width).
module wb_daq_data_packer #(
    parameter int dw          = 32,
    parameter int adc_dw      = 16,
    parameter int SYNC_STAGES = 3
`ifdef DAQ_PACK_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W   = 16
`endif
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
`ifdef DAQ_PACK_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] timeout_cycles,
`endif
    wb_daq_data_packer_if.slave  bus
);

    // Number of slots per word for each sample width.
    localparam logic [3:0] SLOTS_8  = 4'(dw / 8);
    localparam logic [3:0] SLOTS_16 = 4'(dw / 16);
    localparam logic [3:0] SLOTS_32 = 4'(dw / 32);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_prev_r;
    logic                   edge_s;

    logic                   cap_valid_r;
    logic [adc_dw-1:0]      cap_data_r;
    logic [1:0]             cap_width_r;

    logic [dw-1:0]          pack_r;
    logic [3:0]             slot_r;
    logic [1:0]             cur_width_r;

    logic [dw-1:0]          hold_r;
    logic                   hold_valid_r;
    logic [dw-1:0]          data_out_r;
    logic                   push_r;
    logic                   busy_r;
    logic                   overflow_r;

    logic [1:0]             width_s;
    logic [31:0]            samp32_s;
    logic [dw-1:0]          ins_s;
    logic [6:0]             shamt_s;
    logic [3:0]             slots_s;
    logic [dw-1:0]          word_s;
    logic [3:0]             next_slot_s;
    logic                   complete_s;
    logic                   flush_eff_s;
    logic                   drain_s;
    logic                   accept_s;
    logic                   drop_s;
    logic                   hold_valid_nxt_s;
    logic [3:0]             slot_nxt_s;

    assign bus.data_out  = data_out_r;
    assign bus.fifo_push = push_r;
    assign bus.busy      = busy_r;
    assign bus.overflow  = overflow_r;

    // Synchronise the asynchronous strobe and remember the last stage for edge detect.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            sync_r      <= '0;
            sync_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], bus.data_ready};
            sync_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // One event per strobe: a held-high level only produces a single rising edge.
    assign edge_s = sync_r[SYNC_STAGES-1] & ~sync_prev_r;

    // Capture the sample and its width on a qualified edge; reserved width is ignored.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            cap_valid_r <= 1'b0;
            cap_data_r  <= '0;
            cap_width_r <= 2'd0;
        end else begin
            cap_valid_r <= edge_s & bus.enable & (bus.data_width != 2'd3);
            if (edge_s && bus.enable && (bus.data_width != 2'd3)) begin
                cap_data_r  <= bus.adc_data_in;
                cap_width_r <= bus.data_width;
            end
        end
    end

`ifdef DAQ_PACK_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_r;
    logic                 tmo_hit_s;

    // Idle timer for partial words; restarts on every packed sample, saturates at all-ones.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            tmo_cnt_r <= '0;
        end else if ((slot_r == 4'd0) || cap_valid_r) begin
            tmo_cnt_r <= '0;
        end else if (tmo_cnt_r != '1) begin
            tmo_cnt_r <= tmo_cnt_r + TIMEOUT_W'(1);
        end
    end

    assign tmo_hit_s   = (timeout_cycles != '0) && (slot_r != 4'd0) && !cap_valid_r
                         && (tmo_cnt_r == timeout_cycles);
    assign flush_eff_s = bus.flush | tmo_hit_s;
`else
    assign flush_eff_s = bus.flush;
`endif

    // Place the captured sample into the pack word and decide whether the word completes.
    always_comb begin
        width_s  = (slot_r == 4'd0) ? cap_width_r : cur_width_r;
        samp32_s = '0;
        samp32_s[adc_dw-1:0] = cap_data_r;
        ins_s    = '0;
        case (width_s)
            2'd0: begin
                ins_s[7:0] = samp32_s[7:0];
                shamt_s    = {slot_r, 3'b000};
                slots_s    = SLOTS_8;
            end
            2'd1: begin
                ins_s[15:0] = samp32_s[15:0];
                shamt_s     = {slot_r[2:0], 4'b0000};
                slots_s     = SLOTS_16;
            end
            default: begin
                ins_s[31:0] = samp32_s;
                shamt_s     = {slot_r[1:0], 5'b00000};
                slots_s     = SLOTS_32;
            end
        endcase
        if (cap_valid_r) begin
            word_s      = pack_r | (ins_s << shamt_s);
            next_slot_s = slot_r + 4'd1;
        end else begin
            word_s      = pack_r;
            next_slot_s = slot_r;
        end
        // Flush on an empty word with nothing arriving is a no-op.
        complete_s = (cap_valid_r && (next_slot_s == slots_s))
                     || (flush_eff_s && (next_slot_s != 4'd0));
    end

    // Holding-register arbitration: a completed word may refill it in the cycle it drains.
    always_comb begin
        drain_s  = hold_valid_r & ~bus.fifo_full;
        accept_s = complete_s & (~hold_valid_r | drain_s);
        drop_s   = complete_s & ~accept_s;
        if (accept_s) begin
            hold_valid_nxt_s = 1'b1;
        end else if (drain_s) begin
            hold_valid_nxt_s = 1'b0;
        end else begin
            hold_valid_nxt_s = hold_valid_r;
        end
        slot_nxt_s = complete_s ? 4'd0 : next_slot_s;
    end

    // Pack register, slot index and per-word width latch.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            pack_r      <= '0;
            slot_r      <= 4'd0;
            cur_width_r <= 2'd0;
        end else begin
            if (cap_valid_r && (slot_r == 4'd0)) begin
                cur_width_r <= cap_width_r;
            end
            if (complete_s) begin
                pack_r <= '0;
                slot_r <= 4'd0;
            end else begin
                pack_r <= word_s;
                slot_r <= next_slot_s;
            end
        end
    end

    // Holding register, FIFO push strobe, busy and sticky overflow (set beats clear).
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            hold_r       <= '0;
            hold_valid_r <= 1'b0;
            data_out_r   <= '0;
            push_r       <= 1'b0;
            busy_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            push_r <= drain_s;
            if (drain_s) begin
                data_out_r <= hold_r;
            end
            if (accept_s) begin
                hold_r <= word_s;
            end
            hold_valid_r <= hold_valid_nxt_s;
            busy_r       <= (slot_nxt_s != 4'd0) | hold_valid_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_daq_data_packer.sv
// Directed self-checking bench for wb_daq_data_packer (dw=32, adc_dw=16).
module tb_wb_daq_data_packer;

    logic        wb_clk;
    logic        wb_rst;
    int          n_checks;
    int          n_fail;
    int          push_cnt;
    logic [31:0] last_word;
    int          base;
    int          lat;
`ifdef DAQ_PACK_TIMEOUT_EN
    logic [15:0] timeout_cycles;
`endif

    wb_daq_data_packer_if #(.dw(32), .adc_dw(16)) bus ();

    wb_daq_data_packer #(.dw(32), .adc_dw(16), .SYNC_STAGES(3)) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
`ifdef DAQ_PACK_TIMEOUT_EN
        .timeout_cycles (timeout_cycles),
`endif
        .bus            (bus)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    // Record every pushed word, sampled away from the active edge.
    always @(negedge wb_clk) begin
        if (bus.fifo_push === 1'b1) begin
            push_cnt  = push_cnt + 1;
            last_word = bus.data_out;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [15:0] d);
        @(negedge wb_clk);
        bus.adc_data_in = d;
        bus.data_ready  = 1'b1;
        repeat (2) @(negedge wb_clk);
        bus.data_ready  = 1'b0;
        repeat (6) @(negedge wb_clk);
    endtask

    task automatic pulse_flush();
        @(negedge wb_clk);
        bus.flush = 1'b1;
        @(negedge wb_clk);
        bus.flush = 1'b0;
        repeat (4) @(negedge wb_clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        push_cnt = 0;
        last_word = '0;
        wb_rst = 1'b1;
        bus.enable = 1'b1;
        bus.data_ready = 1'b0;
        bus.data_width = 2'd0;
        bus.adc_data_in = 16'h0000;
        bus.flush = 1'b0;
        bus.fifo_full = 1'b0;
        bus.overflow_clr = 1'b0;
`ifdef DAQ_PACK_TIMEOUT_EN
        timeout_cycles = 16'd0;
`endif
        repeat (3) @(negedge wb_clk);
        check("rst_data_out", {32'h0, bus.data_out}, 64'h0);
        check("rst_fifo_push", {63'h0, bus.fifo_push}, 64'h0);
        check("rst_overflow", {63'h0, bus.overflow}, 64'h0);
        check("rst_busy", {63'h0, bus.busy}, 64'h0);
        wb_rst = 1'b0;
        repeat (2) @(negedge wb_clk);

        // 8-bit samples, four per word; last sample timed for latency.
        base = push_cnt;
        strobe(16'h0011);
        strobe(16'h0022);
        strobe(16'h0033);
        @(negedge wb_clk);
        bus.adc_data_in = 16'h0044;
        bus.data_ready  = 1'b1;
        lat = 0;
        while (bus.fifo_push !== 1'b1 && lat < 20) begin
            @(negedge wb_clk);
            lat++;
        end
        bus.data_ready = 1'b0;
        check("latency_ready_to_push", 64'(lat), 64'd6);
        repeat (4) @(negedge wb_clk);
        check("w8_push_count", 64'(push_cnt - base), 64'd1);
        check("w8_word", {32'h0, last_word}, 64'h44332211);
        check("w8_busy_after", {63'h0, bus.busy}, 64'h0);

        // 16-bit samples, then a partial word flushed with zero padding.
        bus.data_width = 2'd1;
        base = push_cnt;
        strobe(16'hAAAA);
        strobe(16'h5555);
        check("w16_word", {32'h0, last_word}, 64'h5555AAAA);
        strobe(16'h1234);
        check("w16_partial_busy", {63'h0, bus.busy}, 64'h1);
        pulse_flush();
        check("w16_flush_word", {32'h0, last_word}, 64'h00001234);
        check("w16_push_count", 64'(push_cnt - base), 64'd2);

        // Flush with an empty word does nothing.
        base = push_cnt;
        pulse_flush();
        check("idle_flush_no_push", 64'(push_cnt - base), 64'd0);

        // 32-bit samples against a full FIFO: hold, drain, hold, drop.
        bus.data_width = 2'd2;
        bus.fifo_full  = 1'b1;
        base = push_cnt;
        strobe(16'h1111);
        check("full_no_push", 64'(push_cnt - base), 64'd0);
        check("full_busy", {63'h0, bus.busy}, 64'h1);
        @(negedge wb_clk);
        bus.fifo_full = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("drain_word", {32'h0, last_word}, 64'h00001111);
        check("drain_push_count", 64'(push_cnt - base), 64'd1);
        bus.fifo_full = 1'b1;
        strobe(16'h2222);
        check("held_no_overflow", {63'h0, bus.overflow}, 64'h0);
        strobe(16'h3333);
        check("drop_overflow", {63'h0, bus.overflow}, 64'h1);
        @(negedge wb_clk);
        bus.overflow_clr = 1'b1;
        @(negedge wb_clk);
        bus.overflow_clr = 1'b0;
        check("overflow_cleared", {63'h0, bus.overflow}, 64'h0);
        bus.fifo_full = 1'b0;
        repeat (6) @(negedge wb_clk);
        check("held_word", {32'h0, last_word}, 64'h00002222);
        check("full_push_count", 64'(push_cnt - base), 64'd2);
        check("full_busy_after", {63'h0, bus.busy}, 64'h0);

        // Reserved width and disabled capture are ignored.
        bus.data_width = 2'd3;
        strobe(16'h0099);
        check("reserved_width_ignored", {63'h0, bus.busy}, 64'h0);
        bus.data_width = 2'd0;
        bus.enable     = 1'b0;
        strobe(16'h0098);
        check("disabled_ignored", {63'h0, bus.busy}, 64'h0);
        bus.enable     = 1'b1;

        // Held-high strobe gives one sample; width change mid-word is deferred.
        base = push_cnt;
        @(negedge wb_clk);
        bus.adc_data_in = 16'h0001;
        bus.data_ready  = 1'b1;
        repeat (20) @(negedge wb_clk);
        bus.data_ready  = 1'b0;
        repeat (6) @(negedge wb_clk);
        check("held_level_busy", {63'h0, bus.busy}, 64'h1);
        bus.data_width = 2'd1;
        strobe(16'hAB02);
        strobe(16'hCD03);
        check("midword_no_push", 64'(push_cnt - base), 64'd0);
        strobe(16'hEF04);
        check("midword_word", {32'h0, last_word}, 64'h04030201);
        check("midword_push_count", 64'(push_cnt - base), 64'd1);

        // Reset mid-word discards the partial word.
        bus.data_width = 2'd0;
        base = push_cnt;
        strobe(16'h0010);
        strobe(16'h0020);
        @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(negedge wb_clk);
        check("midrst_busy", {63'h0, bus.busy}, 64'h0);
        check("midrst_data_out", {32'h0, bus.data_out}, 64'h0);
        check("midrst_no_push", 64'(push_cnt - base), 64'd0);
        strobe(16'h0055);
        strobe(16'h0066);
        strobe(16'h0077);
        strobe(16'h0088);
        check("postrst_word", {32'h0, last_word}, 64'h88776655);
        check("postrst_push_count", 64'(push_cnt - base), 64'd1);

`ifdef DAQ_PACK_TIMEOUT_EN
        // Auto-flush of a lone sample after the idle timeout.
        timeout_cycles = 16'd10;
        base = push_cnt;
        strobe(16'h007F);
        lat = 0;
        while (push_cnt == base && lat < 40) begin
            @(negedge wb_clk);
            lat++;
        end
        check("timeout_push_count", 64'(push_cnt - base), 64'd1);
        check("timeout_word", {32'h0, last_word}, 64'h0000007F);
        timeout_cycles = 16'd0;
`endif

        repeat (2) @(negedge wb_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
